// File: rtl/sram_arb_pkg.sv
// Types and constants shared by the external SRAM arbiter and its requester interface.
package sram_arb_pkg;
  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, WR3} sram_state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic lb_n;
    logic ub_n;
  } strobe_t;

  localparam strobe_t STROBE_IDLE  = '1;
  localparam strobe_t STROBE_RD    = 5'b00100;
  // WR1/WR3 bracket the WE pulse for address setup and data hold
  localparam strobe_t STROBE_WR    = 5'b01100;
  localparam strobe_t STROBE_WR_WE = 5'b01000;
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle: display read port and capture write port.
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic               rd_req;
  logic [SRAM_AW-1:0] rd_addr;
  logic               rd_ack;
  logic [SRAM_DW-1:0] rd_data;
  logic               wr_req;
  logic [SRAM_AW-1:0] wr_addr;
  logic [SRAM_DW-1:0] wr_data;
  logic               wr_ack;
  logic               busy;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_ack, rd_data, wr_ack, busy
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_ack, rd_data, wr_ack, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for the 1Mx16 asynchronous SRAM.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  sram_arbiter_if.slave      bus,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_UB_N
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  sram_state_t        r_state;
  strobe_t            r_strobe;
  logic               r_dq_oe;
  logic [SRAM_AW-1:0] r_addr;
  logic [SRAM_DW-1:0] r_wdata;
  logic [SRAM_DW-1:0] r_rd_data;
  logic               r_rd_ack;
  logic               r_wr_ack;
  logic [3:0]         r_starve;

  logic w_grant_wr;
  logic w_grant_rd;

  // A request still high in its ack cycle is the requester's next transfer,
  // which is what lets back-to-back streams grant in the ack cycle.
  assign w_grant_wr = bus.wr_req && (!bus.rd_req || (r_starve == LIMIT));
  assign w_grant_rd = bus.rd_req && !w_grant_wr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_strobe  <= STROBE_IDLE;
      r_dq_oe   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_rd_ack  <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_starve  <= '0;
    end else begin
      r_rd_ack <= 1'b0;
      r_wr_ack <= 1'b0;
      if (!bus.wr_req) r_starve <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_grant_wr) begin
            r_state  <= WR1;
            r_addr   <= bus.wr_addr;
            r_wdata  <= bus.wr_data;
            r_strobe <= STROBE_WR;
            r_dq_oe  <= 1'b1;
            r_starve <= '0;
          end else if (w_grant_rd) begin
            r_state  <= RD1;
            r_addr   <= bus.rd_addr;
            r_strobe <= STROBE_RD;
            if (bus.wr_req && (r_starve != LIMIT)) r_starve <= r_starve + 4'd1;
          end
        end
        RD1: r_state <= RD2;
        RD2: begin
          r_state   <= IDLE;
          r_strobe  <= STROBE_IDLE;
          r_rd_data <= SRAM_DQ;
          r_rd_ack  <= 1'b1;
        end
        WR1: begin
          r_state  <= WR2;
          r_strobe <= STROBE_WR_WE;
        end
        WR2: begin
          r_state  <= WR3;
          r_strobe <= STROBE_WR;
        end
        WR3: begin
          r_state  <= IDLE;
          r_strobe <= STROBE_IDLE;
          r_dq_oe  <= 1'b0;
          r_wr_ack <= 1'b1;
        end
        default: begin
          r_state  <= IDLE;
          r_strobe <= STROBE_IDLE;
          r_dq_oe  <= 1'b0;
        end
      endcase
    end
  end

  assign SRAM_DQ     = r_dq_oe ? r_wdata : {SRAM_DW{1'bz}};
  assign SRAM_ADDR   = r_addr;
  assign SRAM_CE_N   = r_strobe.ce_n;
  assign SRAM_OE_N   = r_strobe.oe_n;
  assign SRAM_WE_N   = r_strobe.we_n;
  assign SRAM_LB_N   = r_strobe.lb_n;
  assign SRAM_UB_N   = r_strobe.ub_n;
  assign bus.rd_ack  = r_rd_ack;
  assign bus.rd_data = r_rd_data;
  assign bus.wr_ack  = r_wr_ack;
  assign bus.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, directed corner sequences and random bursts
// checked against a request-level arbitration/memory model.
module tb_sram_arbiter;
  localparam int LIM = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  wire  [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  wire         SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;

  sram_arbiter_if bus();

  sram_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N)
  );

  always #5 Clk = ~Clk;

  // asynchronous SRAM model, 256 words aliased on the low address byte
  logic [15:0] sram_mem [256];
  wire         w_sram_rd = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ = w_sram_rd ? sram_mem[SRAM_ADDR[7:0]] : 16'bz;
  always @(posedge Clk) if (!SRAM_CE_N && !SRAM_WE_N) sram_mem[SRAM_ADDR[7:0]] <= SRAM_DQ;

  int   oe_lo_cnt = 0;
  int   turn_viol = 0;
  logic prev_dq_oe = 1'b0;
  always @(negedge Clk) begin
    if (!SRAM_OE_N) oe_lo_cnt <= oe_lo_cnt + 1;
    if (!SRAM_OE_N && (prev_dq_oe || dut.r_dq_oe)) turn_viol <= turn_viol + 1;
    prev_dq_oe <= dut.r_dq_oe;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [15:0] data;   // write data, or expected read data
    int          lat;
    int          we_lo;
    int          oe_lo;
  } vec_t;

  logic [15:0] ref_mem [256];
  logic [15:0] last_rd = 16'h0;

  task automatic xfer(input vec_t v);
    int n, we, oe;
    @(negedge Clk);
    if (v.wr) begin bus.wr_req = 1; bus.wr_addr = v.addr; bus.wr_data = v.data; end
    else      begin bus.rd_req = 1; bus.rd_addr = v.addr; end
    n = 0; we = 0; oe = 0;
    do begin
      @(negedge Clk); n++;
      if (n == 1) chk("addr_latch", SRAM_ADDR, v.addr);
      if (!SRAM_WE_N) begin we++; chk("wr_dq", SRAM_DQ, v.data); end
      if (!SRAM_OE_N) oe++;
    end while (!(bus.rd_ack || bus.wr_ack) && n < 20);
    chk(v.wr ? "wr_ack_port" : "rd_ack_port", v.wr ? bus.wr_ack : bus.rd_ack, 1);
    bus.rd_req = 0; bus.wr_req = 0;
    chk("latency", n, v.lat);
    chk("we_low_cycles", we, v.we_lo);
    chk("oe_low_cycles", oe, v.oe_lo);
    if (v.wr) begin
      chk("rd_data_hold", bus.rd_data, last_rd);
      ref_mem[v.addr[7:0]] = v.data;
    end else begin
      chk("rd_data", bus.rd_data, v.data);
      last_rd = v.data;
    end
  endtask

  logic [19:0] rq_a[$], wq_a[$];
  logic [15:0] wq_d[$];
  int          got_ops[$], ack_cyc[$];

  // Runs all queued reads and writes with both ports requesting continuously.
  task automatic burst();
    int eo[$];
    logic [15:0] ed[$], gd[$];
    int r, w, cnt, ri, wi, guard;
    r = rq_a.size(); w = wq_a.size(); cnt = 0; ri = 0; wi = 0; guard = 0;
    while (r > 0 || w > 0) begin
      if (w > 0 && (r == 0 || cnt == LIM)) begin
        eo.push_back(1); ref_mem[wq_a[wi][7:0]] = wq_d[wi]; wi++; w--; cnt = 0;
      end else begin
        eo.push_back(0); ed.push_back(ref_mem[rq_a[ri][7:0]]); ri++; r--;
        cnt = (w > 0) ? cnt + 1 : 0;
      end
    end
    got_ops.delete(); ack_cyc.delete();
    @(negedge Clk);
    if (rq_a.size() > 0) begin bus.rd_req = 1; bus.rd_addr = rq_a[0]; end
    if (wq_a.size() > 0) begin bus.wr_req = 1; bus.wr_addr = wq_a[0]; bus.wr_data = wq_d[0]; end
    while ((rq_a.size() > 0 || wq_a.size() > 0) && guard < 400) begin
      @(negedge Clk); guard++;
      if (bus.rd_ack && rq_a.size() > 0) begin
        got_ops.push_back(0); gd.push_back(bus.rd_data); ack_cyc.push_back(guard);
        void'(rq_a.pop_front());
        if (rq_a.size() > 0) bus.rd_addr = rq_a[0]; else bus.rd_req = 0;
      end
      if (bus.wr_ack && wq_a.size() > 0) begin
        got_ops.push_back(1); ack_cyc.push_back(guard);
        void'(wq_a.pop_front()); void'(wq_d.pop_front());
        if (wq_a.size() > 0) begin bus.wr_addr = wq_a[0]; bus.wr_data = wq_d[0]; end
        else bus.wr_req = 0;
      end
    end
    bus.rd_req = 0; bus.wr_req = 0;
    if (guard >= 400) chk("burst_timeout", guard, 0);
    rq_a.delete(); wq_a.delete(); wq_d.delete();
    chk("burst_ack_count", got_ops.size(), eo.size());
    for (int i = 0; i < eo.size(); i++)
      chk("grant_order", (i < got_ops.size()) ? got_ops[i] : 2, eo[i]);
    for (int i = 0; i < ed.size(); i++)
      chk("burst_rd_data", (i < gd.size()) ? gd[i] : 32'hdead_0000, ed[i]);
  endtask

  initial begin
    vec_t tv[8];
    int   pat[10];
    int   n, acks, last_drv, first_oe, oe0;
    bit   got;

    tv[0] = '{1, 20'h00010, 16'hBEEF, 4, 1, 0};
    tv[1] = '{0, 20'h00010, 16'hBEEF, 3, 0, 2};
    tv[2] = '{1, 20'hFFFFF, 16'h1234, 4, 1, 0};
    tv[3] = '{0, 20'hFFFFF, 16'h1234, 3, 0, 2};
    tv[4] = '{1, 20'h00000, 16'h0000, 4, 1, 0};
    tv[5] = '{0, 20'h00000, 16'h0000, 3, 0, 2};
    tv[6] = '{1, 20'h00010, 16'h5A5A, 4, 1, 0};
    tv[7] = '{0, 20'h00010, 16'h5A5A, 3, 0, 2};
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    bus.rd_req = 1; bus.wr_req = 1;
    bus.rd_addr = 20'h12345; bus.wr_addr = 20'h54321; bus.wr_data = 16'hAAAA;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 5'h1f);
    chk("rst_dq_oe", dut.r_dq_oe, 0);
    chk("rst_acks", {bus.rd_ack, bus.wr_ack}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    bus.rd_req = 0; bus.wr_req = 0; Reset = 0;
    @(negedge Clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 5'h1f);

    for (int i = 0; i < 8; i++) xfer(tv[i]);

    // write-only stream: fills words 0..15 for the later random reads
    oe0 = oe_lo_cnt;
    for (int i = 0; i < 16; i++) begin wq_a.push_back(20'(i)); wq_d.push_back(16'($urandom)); end
    burst();
    for (int i = 1; i < ack_cyc.size(); i++) chk("wr_stream_spacing", ack_cyc[i] - ack_cyc[i-1], 4);
    chk("wr_stream_oe_low", oe_lo_cnt - oe0, 0);

    for (int i = 0; i < 4; i++) rq_a.push_back(20'($urandom_range(0, 15)));
    burst();
    for (int i = 1; i < ack_cyc.size(); i++) chk("rd_stream_spacing", ack_cyc[i] - ack_cyc[i-1], 3);

    for (int i = 0; i < 8; i++) rq_a.push_back(20'($urandom_range(0, 15)));
    for (int i = 0; i < 2; i++) begin wq_a.push_back(20'($urandom_range(0, 15))); wq_d.push_back(16'($urandom)); end
    burst();
    for (int i = 0; i < 10; i++) chk("starve_pattern", (i < got_ops.size()) ? got_ops[i] : 2, pat[i]);

    // reset pulsed while WE_N is low
    @(negedge Clk);
    bus.wr_req = 1; bus.wr_addr = 20'h00020; bus.wr_data = 16'hDEAD;
    n = 0;
    do begin @(negedge Clk); n++; end while (SRAM_WE_N && n < 10);
    chk("midrst_reached_wr2", SRAM_WE_N, 0);
    Reset = 1;
    @(negedge Clk);
    chk("midrst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 5'h1f);
    chk("midrst_dq_oe", dut.r_dq_oe, 0);
    chk("midrst_busy", bus.busy, 0);
    Reset = 0; bus.wr_req = 0;
    acks = 0;
    repeat (6) begin @(negedge Clk); if (bus.wr_ack) acks++; end
    chk("midrst_no_ack", acks, 0);
    xfer('{0, 20'h00010, 16'h5A5A, 3, 0, 2});

    // write immediately followed by a read of the same word
    @(negedge Clk);
    bus.wr_req = 1; bus.wr_addr = 20'h00030; bus.wr_data = 16'h0F0F;
    @(negedge Clk);
    bus.rd_req = 1; bus.rd_addr = 20'h00030;
    n = 0; last_drv = -1; first_oe = -1; got = 0;
    while (n < 20 && !got) begin
      @(negedge Clk); n++;
      if (dut.r_dq_oe) last_drv = n;
      if (!SRAM_OE_N && first_oe < 0) first_oe = n;
      if (bus.wr_ack) bus.wr_req = 0;
      if (bus.rd_ack) begin bus.rd_req = 0; got = 1; end
    end
    chk("turn_completed", got, 1);
    chk("turn_gap", first_oe - last_drv - 1, 1);
    chk("turn_rd_data", bus.rd_data, 16'h0F0F);

    for (int t = 0; t < 20; t++) begin
      int nr, nw;
      nr = $urandom_range(0, 6); nw = $urandom_range(0, 3);
      if (nr == 0 && nw == 0) nr = 1;
      for (int i = 0; i < nr; i++) rq_a.push_back(20'($urandom_range(0, 15)));
      for (int i = 0; i < nw; i++) begin wq_a.push_back(20'($urandom_range(0, 15))); wq_d.push_back(16'($urandom)); end
      burst();
    end

    chk("turnaround_violations", turn_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
